// File: rtl/slice_cfg_loader_if.sv
// rtl/slice_cfg_loader_if.sv - serial config stream in, committed slice config bus out
// master = config source side, slave = loader side.
interface slice_cfg_loader_if #(
  parameter int PAYLOAD_W = 24
);
  logic                 cfg_valid;
  logic                 cfg_bit;
  logic                 cfg_ready;
  logic                 cfg_abort;
  logic [PAYLOAD_W-1:0] cfg_data;
  logic                 cfg_done;
  logic                 cfg_loaded;
  logic                 cfg_err;
  logic                 busy;

  modport master (
    output cfg_valid, cfg_bit, cfg_abort,
    input  cfg_ready, cfg_data, cfg_done, cfg_loaded, cfg_err, busy
  );

  modport slave (
    input  cfg_valid, cfg_bit, cfg_abort,
    output cfg_ready, cfg_data, cfg_done, cfg_loaded, cfg_err, busy
  );
endinterface

// File: rtl/slice_cfg_loader.sv
// rtl/slice_cfg_loader.sv - sync-hunting serial loader committing LUT mask + FF mode config
// Define CFG_PARITY_EN to append one even-parity bit per frame and reject mismatching frames.
module slice_cfg_loader #(
  parameter int                   PAYLOAD_W = 24,
  parameter int                   SYNC_W    = 8,
  parameter logic [SYNC_W-1:0]    SYNC      = 8'hA5,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  slice_cfg_loader_if.slave cfg
);
  localparam int              CNT_W    = $clog2(PAYLOAD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_W - 1);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_LOAD   = 2'd1,
`ifdef CFG_PARITY_EN
    S_PARITY = 2'd3,
`endif
    S_COMMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_W-1:0]    win_q, win_d;
  logic [PAYLOAD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;

  logic ready;
  logic accept;
  logic sync_hit;
  logic last_bit;
`ifdef CFG_PARITY_EN
  logic parity_ok;
  assign parity_ok = ~(^shift_q ^ cfg.cfg_bit);
`endif

  // Abort takes priority over any offered bit.
  assign accept   = cfg.cfg_valid & ready & ~cfg.cfg_abort;
  assign sync_hit = ({win_q[SYNC_W-2:0], cfg.cfg_bit} == SYNC);
  assign last_bit = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_HUNT;
      win_q    <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      data_q   <= RESET_VAL;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg.cfg_abort) begin
      state_d = S_HUNT;
    end else begin
      case (state_q)
        S_HUNT:   if (accept && sync_hit) state_d = S_LOAD;
`ifdef CFG_PARITY_EN
        S_LOAD:   if (accept && last_bit) state_d = S_PARITY;
        S_PARITY: if (accept) state_d = parity_ok ? S_COMMIT : S_HUNT;
`else
        S_LOAD:   if (accept && last_bit) state_d = S_COMMIT;
`endif
        S_COMMIT: state_d = S_HUNT;
        default:  state_d = S_HUNT;
      endcase
    end
  end

  always_comb begin
    win_d    = '0;
    cnt_d    = '0;
    shift_d  = shift_q;
    data_d   = data_q;
    done_d   = 1'b0;
    loaded_d = loaded_q;
    err_d    = err_q;

    // Window only survives while staying in HUNT, so it is empty on every re-entry.
    if (state_q == S_HUNT && state_d == S_HUNT && !cfg.cfg_abort)
      win_d = accept ? {win_q[SYNC_W-2:0], cfg.cfg_bit} : win_q;

    if (state_q == S_LOAD && state_d == S_LOAD)
      cnt_d = cnt_q + CNT_W'(accept);

    if (state_q == S_LOAD && accept)
      shift_d = {shift_q[PAYLOAD_W-2:0], cfg.cfg_bit};

`ifdef CFG_PARITY_EN
    if (state_q == S_PARITY && accept && !parity_ok)
      err_d = 1'b1;
`endif

    if (state_q == S_COMMIT && !cfg.cfg_abort) begin
      data_d   = shift_q;
      done_d   = 1'b1;
      loaded_d = 1'b1;
      err_d    = 1'b0;
    end
  end

  always_comb begin
    ready = (state_q != S_COMMIT);
  end

  assign cfg.cfg_ready  = ready;
  assign cfg.busy       = (state_q != S_HUNT);
  assign cfg.cfg_data   = data_q;
  assign cfg.cfg_done   = done_q;
  assign cfg.cfg_loaded = loaded_q;
  assign cfg.cfg_err    = err_q;
endmodule

// File: tb/tb_slice_cfg_loader.sv
// tb/tb_slice_cfg_loader.sv - scoreboard bench for slice_cfg_loader
// Expected commits are queued when a frame is driven and popped on each cfg_done.
module tb_slice_cfg_loader;
  localparam int PW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] prev_data = '0;
  logic [PW-1:0] mon_exp;

  slice_cfg_loader_if #(.PAYLOAD_W(PW)) cfg ();

  slice_cfg_loader #(
    .PAYLOAD_W(PW),
    .SYNC_W(8),
    .SYNC(8'hA5),
    .RESET_VAL(24'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg(cfg)
  );

  always #5 clk = ~clk;

  // Commit monitor: every cfg_done must match the oldest queued frame; otherwise cfg_data must hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_data = cfg.cfg_data;
    end else begin
      checks++;
      if (cfg.cfg_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected: cfg_data=%h committed, no frame expected", cfg.cfg_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cfg.cfg_data !== mon_exp) begin
            errors++;
            $display("FAIL commit_data: cfg_data=%h, required %h", cfg.cfg_data, mon_exp);
          end
        end
      end else if (cfg.cfg_data !== prev_data) begin
        errors++;
        $display("FAIL data_leak: cfg_data=%h changed without cfg_done, required %h", cfg.cfg_data, prev_data);
      end
      prev_data = cfg.cfg_data;
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg.cfg_valid = 1'b0;
      cfg.cfg_abort = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b, input int idle_pct);
    int  guard;
    bit  sent;
    guard = 0;
    sent  = 1'b0;
    while (!sent) begin
      @(negedge clk);
      if (guard > 500) begin
        errors++;
        checks++;
        $display("FAIL bit_timeout: cfg_ready=%b for 500 cycles, required 1", cfg.cfg_ready);
        cfg.cfg_valid = 1'b0;
        return;
      end
      guard++;
      if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
        cfg.cfg_valid = 1'b0;
        cfg.cfg_bit   = 1'($urandom_range(0, 1));
      end else if (cfg.cfg_ready) begin
        cfg.cfg_valid = 1'b1;
        cfg.cfg_bit   = b;
        sent          = 1'b1;
      end else begin
        cfg.cfg_valid = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input int idle_pct);
    for (int i = 7; i >= 0; i--) drive_bit(v[i], idle_pct);
  endtask

  task automatic send_payload_bits(input logic [PW-1:0] p, input int nbits, input int idle_pct);
    for (int i = PW - 1; i >= PW - nbits; i--) drive_bit(p[i], idle_pct);
  endtask

  task automatic send_frame(input logic [PW-1:0] p, input logic par, input bit expect_commit,
                            input int idle_pct);
    if (expect_commit) exp_q.push_back(p);
    send_byte(8'hA5, idle_pct);
    send_payload_bits(p, PW, idle_pct);
`ifdef CFG_PARITY_EN
    drive_bit(par, idle_pct);
`else
    if (par === 1'bx) $display("note: parity bit unused");
`endif
  endtask

  task automatic test_reset;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_bit   = 1'b0;
    cfg.cfg_abort = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if (cfg.cfg_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h, required 000000", cfg.cfg_data); end
    checks++; if (cfg.cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", cfg.cfg_done); end
    checks++; if (cfg.cfg_loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b, required 0", cfg.cfg_loaded); end
    checks++; if (cfg.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", cfg.cfg_err); end
    checks++; if (cfg.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", cfg.busy); end
    checks++; if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", cfg.cfg_ready); end
  endtask

  task automatic test_basic_frame;
    send_frame(24'hF00AC3, ^24'hF00AC3, 1'b1, 0);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    checks++; if (cfg.cfg_done !== 1'b0) begin errors++; $display("FAIL basic_early_done: cfg_done=%b after last bit edge, required 0", cfg.cfg_done); end
    checks++; if (cfg.cfg_ready !== 1'b0 || cfg.busy !== 1'b1) begin errors++; $display("FAIL basic_commit_state: ready=%b busy=%b, required ready=0 busy=1", cfg.cfg_ready, cfg.busy); end
    @(negedge clk);
    checks++; if (cfg.cfg_done !== 1'b1) begin errors++; $display("FAIL basic_done: cfg_done=%b one edge after commit, required 1", cfg.cfg_done); end
    checks++; if (cfg.cfg_data !== 24'hF00AC3) begin errors++; $display("FAIL basic_data: got %h, required f00ac3", cfg.cfg_data); end
    @(negedge clk);
    checks++; if (cfg.cfg_done !== 1'b0) begin errors++; $display("FAIL basic_done_width: cfg_done=%b second cycle, required 0", cfg.cfg_done); end
    checks++; if (cfg.cfg_loaded !== 1'b1) begin errors++; $display("FAIL basic_loaded: got %b, required 1", cfg.cfg_loaded); end
  endtask

  task automatic test_false_sync;
    send_byte(8'h3C, 0);
    send_frame(24'h123456, ^24'h123456, 1'b1, 0);
    idle_cycles(3);
    checks++; if (cfg.cfg_data !== 24'h123456) begin errors++; $display("FAIL false_sync_data: got %h, required 123456", cfg.cfg_data); end
  endtask

  task automatic test_abort;
    send_byte(8'hA5, 0);
    send_payload_bits(24'hABCDEF, 10, 0);
    @(negedge clk);
    cfg.cfg_abort = 1'b1;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_bit   = 1'b1;
    @(negedge clk);
    cfg.cfg_abort = 1'b0;
    cfg.cfg_valid = 1'b0;
    checks++; if (cfg.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", cfg.busy); end
    checks++; if (cfg.cfg_data !== 24'h123456) begin errors++; $display("FAIL abort_data_held: got %h, required 123456", cfg.cfg_data); end
    send_frame(24'hABCDEF, ^24'hABCDEF, 1'b1, 0);
    idle_cycles(3);
    checks++; if (cfg.cfg_data !== 24'hABCDEF) begin errors++; $display("FAIL abort_next_frame: got %h, required abcdef", cfg.cfg_data); end

    // Abort landing on the COMMIT cycle must suppress the commit.
    send_frame(24'h654321, ^24'h654321, 1'b0, 0);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    checks++; if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL abort_commit_state: ready=%b, required 0", cfg.cfg_ready); end
    cfg.cfg_abort = 1'b1;
    @(negedge clk);
    cfg.cfg_abort = 1'b0;
    checks++; if (cfg.cfg_done !== 1'b0) begin errors++; $display("FAIL abort_commit_done: got %b, required 0", cfg.cfg_done); end
    checks++; if (cfg.cfg_data !== 24'hABCDEF) begin errors++; $display("FAIL abort_commit_data: got %h, required abcdef", cfg.cfg_data); end
    checks++; if (cfg.busy !== 1'b0) begin errors++; $display("FAIL abort_commit_busy: got %b, required 0", cfg.busy); end
  endtask

  task automatic test_reset_midload;
    send_byte(8'hA5, 0);
    send_payload_bits(24'h5A5A5A, 5, 0);
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (cfg.cfg_data !== 24'h0) begin errors++; $display("FAIL rst_mid_data: got %h, required 000000", cfg.cfg_data); end
    checks++; if (cfg.cfg_loaded !== 1'b0 || cfg.cfg_err !== 1'b0 || cfg.cfg_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags: loaded=%b err=%b done=%b, required 0 0 0", cfg.cfg_loaded, cfg.cfg_err, cfg.cfg_done); end
    checks++; if (cfg.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", cfg.busy); end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b, required 1", cfg.cfg_ready); end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    send_frame(24'h000001, ^24'h000001, 1'b1, 70);
    send_frame(24'hFFFFFE, ^24'hFFFFFE, 1'b1, 70);
    idle_cycles(5);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d pulses, required 2", done_cnt - d0); end
    checks++; if (cfg.cfg_data !== 24'hFFFFFE) begin errors++; $display("FAIL b2b_data: got %h, required fffffe", cfg.cfg_data); end
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity;
    int d0;
    send_frame(24'h000001, 1'b1, 1'b1, 0);
    idle_cycles(3);
    checks++; if (cfg.cfg_err !== 1'b0) begin errors++; $display("FAIL parity_good_err: got %b, required 0", cfg.cfg_err); end
    checks++; if (cfg.cfg_data !== 24'h000001) begin errors++; $display("FAIL parity_good_data: got %h, required 000001", cfg.cfg_data); end
    d0 = done_cnt;
    send_frame(24'h000001, 1'b0, 1'b0, 0);
    idle_cycles(3);
    checks++; if (cfg.cfg_err !== 1'b1) begin errors++; $display("FAIL parity_bad_err: got %b, required 1", cfg.cfg_err); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL parity_bad_done: %0d pulses, required 0", done_cnt - d0); end
    send_frame(24'h0000A5, ^24'h0000A5, 1'b1, 0);
    idle_cycles(3);
    checks++; if (cfg.cfg_err !== 1'b0) begin errors++; $display("FAIL parity_clear_err: got %b, required 0", cfg.cfg_err); end
    checks++; if (cfg.cfg_data !== 24'h0000A5) begin errors++; $display("FAIL parity_clear_data: got %h, required 0000a5", cfg.cfg_data); end
  endtask
`else
  task automatic test_no_parity;
    checks++; if (cfg.cfg_err !== 1'b0) begin errors++; $display("FAIL no_parity_err: got %b, required 0", cfg.cfg_err); end
    checks++; if (cfg.cfg_loaded !== 1'b1) begin errors++; $display("FAIL no_parity_loaded: got %b, required 1", cfg.cfg_loaded); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_false_sync();
    test_abort();
    test_reset_midload();
    test_back_to_back();
`ifdef CFG_PARITY_EN
    test_parity();
`else
    test_no_parity();
`endif
    idle_cycles(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames never committed, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
